uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Serial UART transmitter: the transmit end of the link whose receiver expects 8 data bits, LSB first, even parity, 1 stop bit.
- Accepts one byte per valid/ready handshake and serialises it onto a single line that idles high.
- Sits between a byte-producing client (command/response logic) and the board TX pin.
- Bit timing is derived from the system clock; no separate UART clock domain.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD_RATE, 115200, line bit rate in baud.
- CLKS_PER_BIT (localparam), CLK_FREQ/BAUD_RATE using integer division (868 at defaults), clocks per bit; must be >= 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- tx_data  input  8  byte to send; sampled only on an accepted handshake.
- tx_valid  input  1  client has a byte on tx_data.
- tx_ready  output  1  block can accept a byte; high only in IDLE.
- uart_o  output  1  serial line; idle high.
- tx_busy  output  1  frame in progress, START through STOP inclusive.
- tx_done  output  1  one-cycle pulse at end of the stop bit.

Behaviour:
- Clocking and reset (already decided): one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: uart_o=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE, bit counter=0, baud counter=0, shift register=0.
- All outputs are registered.
- Handshake:
  - A byte is accepted on the rising edge where tx_valid && tx_ready.
  - At acceptance, tx_data is copied into the shift register, parity = XOR of tx_data[7:0] is latched, tx_ready drops and tx_busy rises.
  - tx_data and tx_valid are ignored outside IDLE.
- Latency: the start bit appears on uart_o on the cycle after acceptance.
- Every bit holds for exactly CLKS_PER_BIT clocks.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1.
  - Cleared on acceptance and on every bit boundary.
  - Runs only outside IDLE.
- FSM states:
  - IDLE: uart_o=1. On acceptance -> START.
  - START: uart_o=0 for one bit period -> DATA.
  - DATA: uart_o=shift[0]; shift right each bit boundary. Bit counter 0..7; after bit 7 -> PARITY.
  - PARITY: uart_o=latched parity (even parity: the count of ones over data+parity is even) -> STOP.
  - STOP: uart_o=1 for one bit period. In the last cycle tx_done=1 for one clock -> IDLE; tx_busy=0 and tx_ready=1 from the next cycle.
- Frame length: 11*CLKS_PER_BIT clocks from the start-bit edge to the end of the stop bit.
- Back-to-back: if tx_valid is held high, the next byte is accepted on the first IDLE cycle. The line therefore sees a minimum of one extra idle-high clock after each stop bit.
- Reset mid-frame: uart_o returns high immediately (asynchronously) and the frame is aborted. No tx_done is produced, and the block is ready after reset deasserts.
- rst has priority over everything.
- tx_valid dropping mid-frame has no effect on the frame in progress.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: PARITY state present; frame is 11 bits as described above.
- Undefined:
  - PARITY state removed; DATA goes directly to STOP.
  - Frame is 10 bits (10*CLKS_PER_BIT clocks).
  - No parity register is synthesised.
- The receiver must be built with a matching macro setting.

Decomposition:
- Shared package uart_pkg:
  - state enum IDLE/START/DATA/PARITY/STOP with 3-bit encodings 000/001/010/011/100;
  - DATA_BITS=8;
  - function clks_per_bit(clk_freq, baud_rate).
- Natural sub-module: uart_baud_gen.
  - Per-bit tick counter with clear input and tick output.
  - Reused by the receiver, which adds a half-bit sampling offset.

Test Plan (CLK_FREQ=1000000, BAUD_RATE=100000, so CLKS_PER_BIT=10):
- Reset release: all outputs sit at reset values with uart_o=1. Send 0x55 -> start edge 1 clk after acceptance. Line reads 0,1,0,1,0,1,0,1,0, parity 0, stop 1, each bit 10 clks. tx_done pulses at clk 110.
- Send 0xA7 -> data bits LSB first 1,1,1,0,0,1,0,1, parity bit 1.
- Send 0x00 and 0xFF -> parity bits 0 and 0 respectively.
- tx_valid held high with 0x3C then 0xC3 -> second start bit exactly 1 clk after the first stop bit ends. Exactly two tx_done pulses; tx_data changes mid-frame are ignored.
- Assert rst during DATA bit 3 -> uart_o=1 in the same cycle, no tx_done. A subsequent 0x12 frame is correct.
- UART_TX_PARITY_EN undefined, send 0xA7 -> stop bit directly follows data bit 7; tx_done pulses at clk 100.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmitter and receiver.
//   - 3-bit FSM state encodings (IDLE/START/DATA/PARITY/STOP)
//   - DATA_BITS: payload width of one frame
//   - clks_per_bit(): integer clocks per bit for a given clock and baud rate
// Parity framing is selected with the UART_TX_PARITY_EN macro in the users
// of this package; the encodings here stay fixed either way.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'b000;
  localparam logic [2:0] ST_START  = 3'b001;
  localparam logic [2:0] ST_DATA   = 3'b010;
  localparam logic [2:0] ST_PARITY = 3'b011;
  localparam logic [2:0] ST_STOP   = 3'b100;

  localparam int DATA_BITS = 8;

  // Integer division: the residual baud error is accepted as-is.
  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: per-bit tick generator.
//   clk      : system clock
//   rst      : asynchronous active-high reset
//   en       : count enable (frame in progress)
//   clr      : restart the bit period from zero
//   tick     : last clock of the current bit period (bit boundary)
//   pre_tick : second-to-last clock of the bit period, lets users register
//              a strobe that lands exactly on the boundary cycle
// The counter runs 0..CLKS_PER_BIT-1 and wraps on tick. The receiver reuses
// this block and adds its own half-bit sampling offset.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick,
  output logic pre_tick
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else if (en)          cnt <= cnt + 1'b1;
  end

  assign tick     = en && (cnt == LAST);
  assign pre_tick = en && (cnt == PRE);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, 8 data bits LSB first, 1 stop bit, line idles high.
// Even parity bit is inserted between data and stop when UART_TX_PARITY_EN is
// defined (11-bit frame); otherwise the frame is 10 bits and no parity state
// or register exists.
//   clk      : system clock, rising edge
//   rst      : asynchronous active-high reset
//   tx_data  : byte to send, captured on tx_valid && tx_ready
//   tx_valid : client has a byte
//   tx_ready : can accept a byte (IDLE only)
//   uart_o   : serial line
//   tx_busy  : frame in progress, START through STOP
//   tx_done  : one-clock pulse in the last cycle of the stop bit
// All outputs are registered; uart_o is forced high asynchronously by rst.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       uart_o,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);

  logic [2:0]           state;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 tick, pre_tick;
  logic                 accept;
`ifdef UART_TX_PARITY_EN
  logic                 parity;
`endif

  assign accept = tx_valid && tx_ready;

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .en       (state != ST_IDLE),
    .clr      (accept),
    .tick     (tick),
    .pre_tick (pre_tick)
  );

  // uart_o is loaded with the value of the *next* bit at each boundary so the
  // line changes on the same edge the state does.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      shift    <= '0;
      uart_o   <= 1'b1;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      tx_done <= (state == ST_STOP) && pre_tick;
      case (state)
        ST_IDLE: if (accept) begin
          state    <= ST_START;
          shift    <= tx_data;
          bit_cnt  <= '0;
          uart_o   <= 1'b0;
          tx_ready <= 1'b0;
          tx_busy  <= 1'b1;
`ifdef UART_TX_PARITY_EN
          parity   <= ^tx_data;
`endif
        end
        ST_START: if (tick) begin
          state  <= ST_DATA;
          uart_o <= shift[0];
        end
        ST_DATA: if (tick) begin
          if (bit_cnt == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state  <= ST_PARITY;
            uart_o <= parity;
`else
            state  <= ST_STOP;
            uart_o <= 1'b1;
`endif
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            shift   <= shift >> 1;
            uart_o  <= shift[1];
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: if (tick) begin
          state  <= ST_STOP;
          uart_o <= 1'b1;
        end
`endif
        ST_STOP: if (tick) begin
          state    <= ST_IDLE;
          tx_ready <= 1'b1;
          tx_busy  <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          uart_o   <= 1'b1;
          tx_ready <= 1'b1;
          tx_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx at CLKS_PER_BIT=10.
// Frame table (byte + hand-computed even parity) drives full-frame checks of
// every line cycle, busy/ready/done; hand sequences cover back-to-back
// transfers and reset in the middle of a frame. Frame length follows
// UART_TX_PARITY_EN.
module tb_uart_tx;

  localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int FB = PAR_EN ? 11 : 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, uart_o, tx_busy, tx_done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  uart_tx #(.CLK_FREQ(1000000), .BAUD_RATE(100000)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .uart_o   (uart_o),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (tx_done === 1'b1) done_cnt++;

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] d, input logic p, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (PAR_EN && idx == 9) return p;
    return 1'b1;
  endfunction

  // Entered #1 after the acceptance edge (cycle 1 of the frame). Leaves #1
  // after the edge that starts the first idle cycle following the stop bit.
  task automatic check_frame(input logic [7:0] d, input logic p);
    for (int c = 1; c <= FB*CPB; c++) begin
      chk($sformatf("line %02h c%0d", d, c), uart_o, exp_bit(d, p, (c-1)/CPB));
      chk($sformatf("busy %02h c%0d", d, c), tx_busy, 1);
      chk($sformatf("ready %02h c%0d", d, c), tx_ready, 0);
      chk($sformatf("done %02h c%0d", d, c), tx_done, (c == FB*CPB) ? 1 : 0);
      @(posedge clk); #1;
    end
    chk($sformatf("idle line %02h", d), uart_o, 1);
    chk($sformatf("idle ready %02h", d), tx_ready, 1);
    chk($sformatf("idle busy %02h", d), tx_busy, 0);
    chk($sformatf("idle done %02h", d), tx_done, 0);
  endtask

  task automatic send(input vec_t v);
    chk("ready before send", tx_ready, 1);
    tx_data = v.data; tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0; tx_data = ~v.data;   // must not disturb the frame
    check_frame(v.data, v.par);
  endtask

  initial begin
    // byte, even parity (ones in byte odd -> 1)
    vecs[0] = '{8'h55, 1'b0};
    vecs[1] = '{8'hA7, 1'b1};
    vecs[2] = '{8'h00, 1'b0};
    vecs[3] = '{8'hFF, 1'b0};
    vecs[4] = '{8'h3C, 1'b0};
    vecs[5] = '{8'hC3, 1'b0};
    vecs[6] = '{8'h12, 1'b0};

    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst line", uart_o, 1);
    chk("rst ready", tx_ready, 1);
    chk("rst busy", tx_busy, 0);
    chk("rst done", tx_done, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("post-rst line", uart_o, 1);
    chk("post-rst ready", tx_ready, 1);
    chk("post-rst busy", tx_busy, 0);

    for (int i = 0; i < 4; i++) begin
      send(vecs[i]);
      repeat (3) @(posedge clk);
      #1;
    end

    // Back-to-back with tx_valid held high; data changes mid-frame.
    begin
      int d0;
      d0 = done_cnt;
      tx_data = vecs[4].data; tx_valid = 1'b1;
      @(posedge clk); #1;
      tx_data = vecs[5].data;
      check_frame(vecs[4].data, vecs[4].par);   // ends on the single idle cycle
      @(posedge clk); #1;                       // second acceptance edge
      tx_data = 8'hEE;
      tx_valid = 1'b0;
      check_frame(vecs[5].data, vecs[5].par);
      for (int k = 0; k < 30; k++) begin
        @(posedge clk); #1;
        if (uart_o !== 1'b1 || tx_busy !== 1'b0) begin
          chk("b2b no third frame", {uart_o, tx_busy}, 2'b10);
          break;
        end
      end
      chk("b2b done pulses", done_cnt - d0, 2);
    end

    // Reset during DATA bit 3 of 0xA7 (bit 3 is 0, so the line is low).
    begin
      int d0;
      d0 = done_cnt;
      tx_data = 8'hA7; tx_valid = 1'b1;
      @(posedge clk); #1;
      tx_valid = 1'b0;
      repeat (43) @(posedge clk);
      #1;                                       // cycle 44 = data bit 3
      chk("pre-abort line", uart_o, 0);
      chk("pre-abort busy", tx_busy, 1);
      rst = 1'b1; tx_valid = 1'b1;
      #1;
      chk("abort line async", uart_o, 1);
      chk("abort ready", tx_ready, 1);
      chk("abort busy", tx_busy, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("abort held line", uart_o, 1);
      rst = 1'b0; tx_valid = 1'b0;
      repeat (3 * CPB * FB) @(posedge clk);
      #1;
      chk("abort no done", done_cnt - d0, 0);
      chk("abort idle line", uart_o, 1);
      send(vecs[6]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
